// File: rtl/y_dct.sv
// y_dct: forward 8x8 2-D DCT for the JPEG luminance path.
// Row MACs per sample, column MACs per finished row, 64 results out in parallel.
module y_dct (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  data_in,
    output logic [10:0] Z11_final,
    output logic [10:0] Z12_final,
    output logic [10:0] Z13_final,
    output logic [10:0] Z14_final,
    output logic [10:0] Z15_final,
    output logic [10:0] Z16_final,
    output logic [10:0] Z17_final,
    output logic [10:0] Z18_final,
    output logic [10:0] Z21_final,
    output logic [10:0] Z22_final,
    output logic [10:0] Z23_final,
    output logic [10:0] Z24_final,
    output logic [10:0] Z25_final,
    output logic [10:0] Z26_final,
    output logic [10:0] Z27_final,
    output logic [10:0] Z28_final,
    output logic [10:0] Z31_final,
    output logic [10:0] Z32_final,
    output logic [10:0] Z33_final,
    output logic [10:0] Z34_final,
    output logic [10:0] Z35_final,
    output logic [10:0] Z36_final,
    output logic [10:0] Z37_final,
    output logic [10:0] Z38_final,
    output logic [10:0] Z41_final,
    output logic [10:0] Z42_final,
    output logic [10:0] Z43_final,
    output logic [10:0] Z44_final,
    output logic [10:0] Z45_final,
    output logic [10:0] Z46_final,
    output logic [10:0] Z47_final,
    output logic [10:0] Z48_final,
    output logic [10:0] Z51_final,
    output logic [10:0] Z52_final,
    output logic [10:0] Z53_final,
    output logic [10:0] Z54_final,
    output logic [10:0] Z55_final,
    output logic [10:0] Z56_final,
    output logic [10:0] Z57_final,
    output logic [10:0] Z58_final,
    output logic [10:0] Z61_final,
    output logic [10:0] Z62_final,
    output logic [10:0] Z63_final,
    output logic [10:0] Z64_final,
    output logic [10:0] Z65_final,
    output logic [10:0] Z66_final,
    output logic [10:0] Z67_final,
    output logic [10:0] Z68_final,
    output logic [10:0] Z71_final,
    output logic [10:0] Z72_final,
    output logic [10:0] Z73_final,
    output logic [10:0] Z74_final,
    output logic [10:0] Z75_final,
    output logic [10:0] Z76_final,
    output logic [10:0] Z77_final,
    output logic [10:0] Z78_final,
    output logic [10:0] Z81_final,
    output logic [10:0] Z82_final,
    output logic [10:0] Z83_final,
    output logic [10:0] Z84_final,
    output logic [10:0] Z85_final,
    output logic [10:0] Z86_final,
    output logic [10:0] Z87_final,
    output logic [10:0] Z88_final,
    output logic        output_enable
);

    // C[u][n] = round(2048*cos((2n+1)*u*pi/16)), row 0 flattened to 1448.
    // The angle index is taken mod 32 and folded onto the first quadrant table.
    function automatic logic signed [11:0] coef(input logic [2:0] u,
                                                input logic [2:0] n);
        logic [4:0]         m;
        logic [3:0]         idx;
        logic               neg;
        logic signed [11:0] mag;
        m   = {1'b0, n, 1'b1} * {2'b00, u};
        neg = m[4];
        if (m[3:0] > 4'd8) begin
            idx = 4'd0 - m[3:0];
            neg = ~neg;
        end else begin
            idx = m[3:0];
        end
        case (idx)
            4'd1:    mag = 12'sd2009;
            4'd2:    mag = 12'sd1892;
            4'd3:    mag = 12'sd1703;
            4'd4:    mag = 12'sd1448;
            4'd5:    mag = 12'sd1138;
            4'd6:    mag = 12'sd784;
            4'd7:    mag = 12'sd400;
            default: mag = 12'sd0;
        endcase
        if (u == 3'd0) begin
            return 12'sd1448;
        end
        return neg ? -mag : mag;
    endfunction

    // Round half toward +inf at 2^24, then clamp to the 11-bit signed range.
    function automatic logic [10:0] sat11(input logic signed [36:0] s);
        logic signed [36:0] r;
        r = (s + 37'sd8388608) >>> 24;
        if (r > 37'sd1023) begin
            return 11'h3ff;
        end
        if (r < -37'sd1024) begin
            return 11'h400;
        end
        return r[10:0];
    endfunction

    logic [5:0]         cnt;
    logic signed [7:0]  xs;
    logic               row_end;
    logic signed [23:0] yacc   [8];
    logic signed [23:0] ynext  [8];
    logic signed [23:0] rowbuf [8];
    logic [2:0]         col_row;
    logic [2:0]         col_v;
    logic               col_busy;
    logic signed [36:0] acc    [8][8];
    logic signed [36:0] csum   [8];
    logic [10:0]        pz     [8][8];
    logic [10:0]        zq     [8][8];
    logic               last_step;
    logic               pend;
    logic [2:0]         pend_cnt;
    logic               oe;

    assign xs        = {~data_in[7], data_in[6:0]};
    assign row_end   = enable && (cnt[2:0] == 3'd7);
    assign last_step = col_busy && (col_row == 3'd7) && (col_v == 3'd7);

    // Row pass: each sample feeds all eight column frequencies of its row.
    always_comb begin
        for (int v = 0; v < 8; v++) begin
            ynext[v] = ((cnt[2:0] == 3'd0) ? 24'sd0 : yacc[v])
                     + 24'(coef(3'(v), cnt[2:0])) * 24'(xs);
        end
    end

    // Sample counter and row accumulators advance only on enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int v = 0; v < 8; v++) begin
                yacc[v] <= '0;
            end
        end else if (enable) begin
            cnt <= cnt + 6'd1;
            for (int v = 0; v < 8; v++) begin
                yacc[v] <= ynext[v];
            end
        end
    end

    // Column sequencer: a finished row is latched and walked one v per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_busy <= 1'b0;
            col_v    <= '0;
            col_row  <= '0;
            for (int v = 0; v < 8; v++) begin
                rowbuf[v] <= '0;
            end
        end else if (row_end) begin
            col_busy <= 1'b1;
            col_v    <= '0;
            col_row  <= cnt[5:3];
            for (int v = 0; v < 8; v++) begin
                rowbuf[v] <= ynext[v];
            end
        end else if (col_busy) begin
            col_v <= col_v + 3'd1;
            if (col_v == 3'd7) begin
                col_busy <= 1'b0;
            end
        end
    end

    // Column pass: eight row-frequency MACs for the current column.
    always_comb begin
        for (int u = 0; u < 8; u++) begin
            csum[u] = ((col_row == 3'd0) ? 37'sd0 : acc[u][col_v])
                    + 37'(coef(3'(u), col_row)) * 37'(rowbuf[col_v]);
        end
    end

    // Partial sums build up in acc; the last row goes straight to the
    // pending bank so the next block may reuse acc immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int u = 0; u < 8; u++) begin
                for (int v = 0; v < 8; v++) begin
                    acc[u][v] <= '0;
                    pz[u][v]  <= '0;
                end
            end
        end else if (col_busy) begin
            for (int u = 0; u < 8; u++) begin
                if (col_row == 3'd7) begin
                    pz[u][col_v] <= sat11(csum[u]);
                end else begin
                    acc[u][col_v] <= csum[u];
                end
            end
        end
    end

    // Publish the pending bank 8 cycles after the last column step,
    // i.e. 16 cycles after the block's final sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 1'b0;
            pend_cnt <= '0;
            oe       <= 1'b0;
            for (int u = 0; u < 8; u++) begin
                for (int v = 0; v < 8; v++) begin
                    zq[u][v] <= '0;
                end
            end
        end else if (last_step) begin
            pend     <= 1'b1;
            pend_cnt <= 3'd7;
        end else if (pend) begin
            if (pend_cnt == 3'd0) begin
                pend <= 1'b0;
                oe   <= 1'b1;
                zq   <= pz;
            end else begin
                pend_cnt <= pend_cnt - 3'd1;
            end
        end
    end

    assign output_enable = oe;

    assign Z11_final = zq[0][0];
    assign Z12_final = zq[0][1];
    assign Z13_final = zq[0][2];
    assign Z14_final = zq[0][3];
    assign Z15_final = zq[0][4];
    assign Z16_final = zq[0][5];
    assign Z17_final = zq[0][6];
    assign Z18_final = zq[0][7];
    assign Z21_final = zq[1][0];
    assign Z22_final = zq[1][1];
    assign Z23_final = zq[1][2];
    assign Z24_final = zq[1][3];
    assign Z25_final = zq[1][4];
    assign Z26_final = zq[1][5];
    assign Z27_final = zq[1][6];
    assign Z28_final = zq[1][7];
    assign Z31_final = zq[2][0];
    assign Z32_final = zq[2][1];
    assign Z33_final = zq[2][2];
    assign Z34_final = zq[2][3];
    assign Z35_final = zq[2][4];
    assign Z36_final = zq[2][5];
    assign Z37_final = zq[2][6];
    assign Z38_final = zq[2][7];
    assign Z41_final = zq[3][0];
    assign Z42_final = zq[3][1];
    assign Z43_final = zq[3][2];
    assign Z44_final = zq[3][3];
    assign Z45_final = zq[3][4];
    assign Z46_final = zq[3][5];
    assign Z47_final = zq[3][6];
    assign Z48_final = zq[3][7];
    assign Z51_final = zq[4][0];
    assign Z52_final = zq[4][1];
    assign Z53_final = zq[4][2];
    assign Z54_final = zq[4][3];
    assign Z55_final = zq[4][4];
    assign Z56_final = zq[4][5];
    assign Z57_final = zq[4][6];
    assign Z58_final = zq[4][7];
    assign Z61_final = zq[5][0];
    assign Z62_final = zq[5][1];
    assign Z63_final = zq[5][2];
    assign Z64_final = zq[5][3];
    assign Z65_final = zq[5][4];
    assign Z66_final = zq[5][5];
    assign Z67_final = zq[5][6];
    assign Z68_final = zq[5][7];
    assign Z71_final = zq[6][0];
    assign Z72_final = zq[6][1];
    assign Z73_final = zq[6][2];
    assign Z74_final = zq[6][3];
    assign Z75_final = zq[6][4];
    assign Z76_final = zq[6][5];
    assign Z77_final = zq[6][6];
    assign Z78_final = zq[6][7];
    assign Z81_final = zq[7][0];
    assign Z82_final = zq[7][1];
    assign Z83_final = zq[7][2];
    assign Z84_final = zq[7][3];
    assign Z85_final = zq[7][4];
    assign Z86_final = zq[7][5];
    assign Z87_final = zq[7][6];
    assign Z88_final = zq[7][7];

endmodule

// File: tb/tb_y_dct.sv
// tb_y_dct: scoreboard bench for y_dct.
// Stimulus queues expected blocks with their due cycle; a monitor checks every cycle.
module tb_y_dct;

    logic            clk     = 1'b0;
    logic            rst     = 1'b0;
    logic            enable  = 1'b0;
    logic [7:0]      data_in = 8'd0;
    wire [63:0][10:0] act;
    wire             oe;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int               due;
        logic [63:0][10:0] z;
    } exp_t;

    exp_t              exp_q[$];
    logic [63:0][10:0] cur_z  = '0;
    logic              cur_oe = 1'b0;

    y_dct dut (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
        .Z11_final(act[0]),  .Z12_final(act[1]),  .Z13_final(act[2]),  .Z14_final(act[3]),
        .Z15_final(act[4]),  .Z16_final(act[5]),  .Z17_final(act[6]),  .Z18_final(act[7]),
        .Z21_final(act[8]),  .Z22_final(act[9]),  .Z23_final(act[10]), .Z24_final(act[11]),
        .Z25_final(act[12]), .Z26_final(act[13]), .Z27_final(act[14]), .Z28_final(act[15]),
        .Z31_final(act[16]), .Z32_final(act[17]), .Z33_final(act[18]), .Z34_final(act[19]),
        .Z35_final(act[20]), .Z36_final(act[21]), .Z37_final(act[22]), .Z38_final(act[23]),
        .Z41_final(act[24]), .Z42_final(act[25]), .Z43_final(act[26]), .Z44_final(act[27]),
        .Z45_final(act[28]), .Z46_final(act[29]), .Z47_final(act[30]), .Z48_final(act[31]),
        .Z51_final(act[32]), .Z52_final(act[33]), .Z53_final(act[34]), .Z54_final(act[35]),
        .Z55_final(act[36]), .Z56_final(act[37]), .Z57_final(act[38]), .Z58_final(act[39]),
        .Z61_final(act[40]), .Z62_final(act[41]), .Z63_final(act[42]), .Z64_final(act[43]),
        .Z65_final(act[44]), .Z66_final(act[45]), .Z67_final(act[46]), .Z68_final(act[47]),
        .Z71_final(act[48]), .Z72_final(act[49]), .Z73_final(act[50]), .Z74_final(act[51]),
        .Z75_final(act[52]), .Z76_final(act[53]), .Z77_final(act[54]), .Z78_final(act[55]),
        .Z81_final(act[56]), .Z82_final(act[57]), .Z83_final(act[58]), .Z84_final(act[59]),
        .Z85_final(act[60]), .Z86_final(act[61]), .Z87_final(act[62]), .Z88_final(act[63]),
        .output_enable(oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-derived block results: a flat block only has a DC term.
    function automatic logic [63:0][10:0] blk(input logic [10:0] z11);
        logic [63:0][10:0] z;
        z    = '0;
        z[0] = z11;
        return z;
    endfunction

    // Ramp 0..63: only row 0 and column 0 odd frequencies are non-zero.
    function automatic logic [63:0][10:0] ramp_z();
        logic [63:0][10:0] z;
        z     = '0;
        z[0]  = 11'(-772);
        z[1]  = 11'(-18);
        z[3]  = 11'(-2);
        z[5]  = 11'(-1);
        z[8]  = 11'(-146);
        z[24] = 11'(-15);
        z[40] = 11'(-5);
        z[56] = 11'(-1);
        return z;
    endfunction

    task automatic send(input logic [7:0] p);
        @(negedge clk);
        enable  = 1'b1;
        data_in = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_block(input bit ramp, input logic [7:0] c,
                              input int gap_at, input logic [63:0][10:0] z);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            send(ramp ? 8'(k) : c);
            if (k == gap_at) idle(10);
        end
        e.due = cyc + 17;
        e.z   = z;
        exp_q.push_back(e);
    endtask

    // Monitor: retire expected blocks at their due cycle, compare every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                exp_q.delete();
                cur_z  = '0;
                cur_oe = 1'b0;
            end else if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
                cur_z  = exp_q[0].z;
                cur_oe = 1'b1;
                void'(exp_q.pop_front());
            end
            checks++;
            if (act !== cur_z || oe !== cur_oe) begin
                int  idx;
                bit  found;
                idx   = 0;
                found = 1'b0;
                for (int i = 0; i < 64; i++) begin
                    if (!found && act[i] !== cur_z[i]) begin
                        idx   = i;
                        found = 1'b1;
                    end
                end
                errors++;
                $display("FAIL cycle %0d Z%0d%0d_final got %0d want %0d, output_enable got %b want %b",
                         cyc, idx / 8 + 1, idx % 8 + 1,
                         $signed(act[idx]), $signed(cur_z[idx]), oe, cur_oe);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);
        send_block(1'b0, 8'd128, -1, blk(11'd0));
        idle(20);
        send_block(1'b0, 8'd255, -1, blk(11'd1016));
        idle(20);
        send_block(1'b0, 8'd0, -1, blk(11'h400));
        idle(20);
        send_block(1'b1, 8'd0, -1, ramp_z());
        idle(25);
        send_block(1'b1, 8'd0, -1, ramp_z());
        send_block(1'b0, 8'd128, -1, blk(11'd0));
        idle(20);
        send_block(1'b0, 8'd255, 30, blk(11'd1016));
        idle(20);
        send_block(1'b1, 8'd0, -1, ramp_z());
        idle(5);
        do_reset(3);
        idle(25);
        send_block(1'b0, 8'd255, -1, blk(11'd1016));
        idle(20);
        for (int k = 0; k < 30; k++) send(8'(k));
        do_reset(3);
        idle(2);
        send_block(1'b0, 8'd255, -1, blk(11'd1016));
        idle(25);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d blocks still pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
